multi_one_window_detector: RTL
==============================

// Module: multi_one_window_detector
// PURPOSE
// Serial-bit "multiple ones" detector, generalised. Counts 1s on a 1-bit
// stream qualified by en, in one of three run-time modes: consecutive run,
// sliding window of WIN bits, or non-overlapping WIN-bit blocks. Flags y when
// the count reaches THRESH. Sits in the serial-protocol FSM library, after
// the bit-sampling stage.
// PARAMETERS
// WIN     8                  window/block length in bits; legal range >=2
// THRESH  2                  detect threshold; legal range 1..WIN
// CNT_W   $clog2(WIN+1)      width of the count output
// PORTS
// clk    in   1      rising-edge clock; the only clock
// rst    in   1      synchronous reset, active low
// en     in   1      i is a valid bit this cycle
// i      in   1      serial data bit
// clr    in   1      synchronous soft clear of all detection state
// mode   in   2      0=RUN, 1=SLIDE, 2=BLOCK, 3=reserved (behaves as RUN)
// y      out  1      detect flag, registered
// count  out  CNT_W  current count, registered (meaning is per mode)
// full   out  1      SLIDE: window holds WIN bits; other modes: 0
// blk    out  1      BLOCK: 1-cycle pulse when a block completes; else 0
// BEHAVIOUR
// - Reset is synchronous: on the edge where rst=0, y, count, full and blk go
//   to 0. The window shift register, fill counter and mode_q are also cleared.
//   Reset overrides clr, en and mode changes.
// - Priority per edge: rst > clr > mode change > en.
// - clr=1 clears the same state as reset; a bit presented with clr in the
//   same cycle is dropped.
// - Mode register mode_q: if mode != mode_q, the edge clears state as clr
//   would and loads mode_q. Any en bit on that edge is dropped.
// - A bit is accepted on an edge with en=1. Outputs reflect it after that
//   edge, giving 1-cycle latency. With en=0 everything holds and blk=0.
// - Control FSM: EMPTY (no bits since clear), FILL (fewer than WIN bits
//   seen), STEADY (WIN bits seen).
//   - EMPTY goes to FILL on the first accepted bit.
//   - FILL goes to STEADY on accepted bit number WIN.
//   - SLIDE stays in STEADY.
//   - BLOCK returns from STEADY to EMPTY on the completing edge.
//   - RUN does not use fill; it stays in EMPTY/FILL and never asserts full.
// - RUN: on i=1, count = min(count+1, WIN); on i=0, count = 0.
//   y = (run length >= THRESH), evaluated before saturation.
// - SLIDE: count = ones among the last min(bits seen, WIN) accepted bits.
//   - In STEADY: count += i - oldest bit.
//   - y = (count >= THRESH).
//   - full = 1 in STEADY.
// - BLOCK: count = ones in the current partial block.
//   - On the edge accepting bit WIN of a block: y is loaded with
//     (block total >= THRESH), count goes to 0, and blk=1 for exactly that
//     cycle.
//   - y holds between block completions.
// - count never exceeds WIN and never wraps. The fill counter saturates
//   at WIN.
// - Out-of-range parameters produce a simulation $error at elaboration.
// TESTING (WIN=8, THRESH=2 unless noted; bit sequences are accepted en=1 bits)
// 1 RUN:   i=1,0,1,1,1,0 -> y=0,0,0,1,1,0; count=1,0,1,2,3,0 (each 1 cycle
//   after its bit). 10 consecutive 1s -> count saturates at 8, y stays 1.
// 2 SLIDE: i=1,1 then seven 0s
//   - after bit 2: count=2, y=1.
//   - after bit 8: full=1, count=2.
//   - after bit 9 (first 1 leaves the window): count=1, y=0.
// 3 BLOCK: block 1,0,0,0,0,0,0,1 -> blk=1 for 1 cycle after bit 8, y=1,
//   count=0. Next block all 0s -> blk pulse, y=0.
// 4 en gaps: RUN 1,1 with 3 idle en=0 cycles between the bits -> y=1 after
//   the 2nd bit; outputs hold through the gaps; blk never asserts on idles.
// 5 clr/mode: clr=1 with en=1,i=1 in SLIDE, count=1 -> count=0, full=0, y=0,
//   bit dropped. Change mode 1->2 mid-window -> state cleared; the next 8
//   bits form a fresh block.
// 6 reset mid-op: BLOCK after 5 bits, rst=0 for 1 edge -> y=count=blk=full=0
//   on that edge. The next block completes after 8 new bits.

Source files
------------

// File: rtl/multi_one_window_detector_if.sv
`default_nettype none
// ============================================================================
// Module : multi_one_window_detector_if
// Brief  : Stream/result bundle for the multi-one window detector.
// Rev    : 1.0  initial release
// ============================================================================
interface multi_one_window_detector_if #(
   parameter int CNT_W = 4
) ();
   logic             en;
   logic             i;
   logic             clr;
   logic [1:0]       mode;
   logic             y;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             blk;

   modport master (output en, i, clr, mode, input y, count, full, blk);
   modport slave  (input en, i, clr, mode, output y, count, full, blk);
endinterface
`default_nettype wire

// File: rtl/multi_one_window_detector.sv
`default_nettype none
// ============================================================================
// Module : multi_one_window_detector
// Brief  : Counts ones on a serial stream in RUN, SLIDE or BLOCK mode and
//          flags when the count reaches THRESH.
// Rev    : 1.0  initial release
// ============================================================================
module multi_one_window_detector #(
   parameter int WIN    = 8,
   parameter int THRESH = 2,
   parameter int CNT_W  = $clog2(WIN + 1)
) (
   input  wire logic                        clk,
   input  wire logic                        rst,
   multi_one_window_detector_if.slave       bus
);

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_FILL   = 2'd1,
      S_STEADY = 2'd2
   } state_t;

   localparam logic [1:0]     C_MODE_SLIDE = 2'd1;
   localparam logic [1:0]     C_MODE_BLOCK = 2'd2;
   localparam logic [CNT_W:0] C_WIN        = (CNT_W+1)'(WIN);
   localparam logic [CNT_W:0] C_THRESH     = (CNT_W+1)'(THRESH);

   generate
      if (WIN < 2 || THRESH < 1 || THRESH > WIN) begin : g_param_err
         $error("multi_one_window_detector: illegal WIN/THRESH");
      end
   endgenerate

   state_t           r_state;
   logic [1:0]       r_mode_q;
   logic [WIN-1:0]   r_win;
   logic [CNT_W-1:0] r_fill;
   logic             r_y;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_blk;

   logic [CNT_W:0]   w_cnt_inc;
   logic [CNT_W:0]   w_slide;
   logic [CNT_W:0]   w_fill_inc;
   logic             w_mode_chg;

   assign w_cnt_inc  = {1'b0, r_count} + {{CNT_W{1'b0}}, bus.i};
   // Oldest bit sits at the top of the shift register once the window is full.
   assign w_slide    = w_cnt_inc - {{CNT_W{1'b0}}, r_win[WIN-1]};
   assign w_fill_inc = {1'b0, r_fill} + {{CNT_W{1'b0}}, 1'b1};
   assign w_mode_chg = (bus.mode != r_mode_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_EMPTY;
         r_mode_q <= 2'd0;
         r_win    <= '0;
         r_fill   <= '0;
         r_y      <= 1'b0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_blk    <= 1'b0;
      end else if (bus.clr || w_mode_chg) begin
         // Tracking the live mode here keeps a clear from spawning a second,
         // spurious mode-change clear on the following edge.
         r_state  <= S_EMPTY;
         r_mode_q <= bus.mode;
         r_win    <= '0;
         r_fill   <= '0;
         r_y      <= 1'b0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_blk    <= 1'b0;
      end else if (bus.en) begin
         case (r_mode_q)
            C_MODE_SLIDE: begin
               r_win <= {r_win[WIN-2:0], bus.i};
               r_blk <= 1'b0;
               if (r_state == S_STEADY) begin
                  r_count <= w_slide[CNT_W-1:0];
                  r_y     <= (w_slide >= C_THRESH);
                  r_full  <= 1'b1;
               end else begin
                  r_count <= w_cnt_inc[CNT_W-1:0];
                  r_y     <= (w_cnt_inc >= C_THRESH);
                  r_fill  <= w_fill_inc[CNT_W-1:0];
                  if (w_fill_inc == C_WIN) begin
                     r_state <= S_STEADY;
                     r_full  <= 1'b1;
                  end else begin
                     r_state <= S_FILL;
                     r_full  <= 1'b0;
                  end
               end
            end
            C_MODE_BLOCK: begin
               r_full <= 1'b0;
               if (w_fill_inc == C_WIN) begin
                  r_y     <= (w_cnt_inc >= C_THRESH);
                  r_count <= '0;
                  r_blk   <= 1'b1;
                  r_fill  <= '0;
                  r_state <= S_EMPTY;
               end else begin
                  r_count <= w_cnt_inc[CNT_W-1:0];
                  r_blk   <= 1'b0;
                  r_fill  <= w_fill_inc[CNT_W-1:0];
                  r_state <= S_FILL;
               end
            end
            default: begin
               // RUN (and reserved): y uses the unsaturated run length.
               r_full  <= 1'b0;
               r_blk   <= 1'b0;
               r_state <= S_FILL;
               if (bus.i) begin
                  r_count <= (w_cnt_inc > C_WIN) ? C_WIN[CNT_W-1:0] : w_cnt_inc[CNT_W-1:0];
                  r_y     <= (w_cnt_inc >= C_THRESH);
               end else begin
                  r_count <= '0;
                  r_y     <= 1'b0;
               end
            end
         endcase
      end else begin
         r_blk <= 1'b0;
      end
   end

   assign bus.y     = r_y;
   assign bus.count = r_count;
   assign bus.full  = r_full;
   assign bus.blk   = r_blk;

endmodule
`default_nettype wire
